// File: rtl/mux_scan_serializer_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_serializer_pkg
// Shared definitions for the scan serializer: FSM state encoding and the
// default word / select widths.
// Ports: none (package).
// -----------------------------------------------------------------------------
package mux_scan_serializer_pkg;

   localparam int WIDTH = 16;
   localparam int SEL_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : mux_scan_serializer_pkg

// File: rtl/sel16_mux.sv
// -----------------------------------------------------------------------------
// sel16_mux
// Purely combinational 16:1 bit selector built as a two-level tree of 4:1
// selectors: sel[1:0] picks within each nibble, sel[3:2] picks the nibble.
// Ports:
//   d    in  16  data word
//   sel  in  4   bit index
//   q    out 1   d[sel]
// -----------------------------------------------------------------------------
module sel16_mux (
   input  logic [15:0] d,
   input  logic [3:0]  sel,
   output logic        q
);

   logic [3:0] stage1;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_nibble
         logic [3:0] grp;
         assign grp        = d[gi*4 +: 4];
         assign stage1[gi] = grp[sel[1:0]];
      end
   endgenerate

   assign q = stage1[sel[3:2]];

endmodule : sel16_mux

// File: rtl/mux_scan_serializer.sv
// -----------------------------------------------------------------------------
// mux_scan_serializer
// Parallel-to-serial converter: accepts a word with a valid/ready handshake,
// then sweeps the bit select from the start index to the end index, emitting
// one bit per accepted downstream beat, followed by a one-cycle done pulse.
// Ports:
//   clk         in  1      system clock, rising edge
//   rst         in  1      asynchronous active-high reset
//   load        in  1      input valid (accepted when load && in_ready)
//   din         in  WIDTH  parallel word, captured on acceptance
//   msb_first   in  1      direction, captured on acceptance (1 = MSB first)
//   in_ready    out 1      block can accept a word
//   sout_ready  in  1      downstream accepts the current bit
//   sout        out 1      current bit, data_reg[sel]
//   sout_valid  out 1      sout is valid
//   sout_last   out 1      current bit is the last one of the word
//   sel         out SEL_W  current select value
//   done        out 1      one-cycle pulse after the last bit is accepted
// -----------------------------------------------------------------------------
module mux_scan_serializer #(
   parameter int WIDTH = mux_scan_serializer_pkg::WIDTH,
   parameter int SEL_W = mux_scan_serializer_pkg::SEL_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             msb_first,
   output logic             in_ready,
   input  logic             sout_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_last,
   output logic [SEL_W-1:0] sel,
   output logic             done
);

   import mux_scan_serializer_pkg::*;

   // The selector tree is a fixed 16:1 structure, so WIDTH must stay at
   // 16 and SEL_W at 4 while sel16_mux is the bit selector.
   localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(WIDTH - 1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] data_reg,  data_next;
   logic             dir_reg,   dir_next;
   logic [SEL_W-1:0] sel_reg,   sel_next;
   logic [SEL_W-1:0] end_idx;
   logic             at_end;

   // Sweep ends at 0 when going MSB-first, at the top index otherwise.
   assign end_idx = dir_reg ? '0 : SEL_MAX;
   assign at_end  = (sel_reg == end_idx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         data_reg  <= '0;
         dir_reg   <= 1'b0;
         sel_reg   <= '0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
         dir_reg   <= dir_next;
         sel_reg   <= sel_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
      dir_next   = dir_reg;
      sel_next   = sel_reg;
      in_ready   = 1'b0;
      sout_valid = 1'b0;
      done       = 1'b0;

      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (load) begin
               data_next  = din;
               dir_next   = msb_first;
               sel_next   = msb_first ? SEL_MAX : '0;
               state_next = SHIFT;
            end
         end

         SHIFT: begin
            sout_valid = 1'b1;
            // Without sout_ready nothing moves, so the bit is neither
            // dropped nor repeated. On the last beat sel stays put.
            if (sout_ready) begin
               if (at_end) begin
                  state_next = DONE;
               end else if (dir_reg) begin
                  sel_next = sel_reg - 1'b1;
               end else begin
                  sel_next = sel_reg + 1'b1;
               end
            end
         end

         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign sout_last = sout_valid & at_end;
   assign sel       = sel_reg;

   // sout comes straight from registered data and select, so after reset
   // it is a defined 0 (data_reg = 0, sel = 0).
   sel16_mux u_sel16_mux (
      .d   (data_reg),
      .sel (sel_reg),
      .q   (sout)
   );

endmodule : mux_scan_serializer

// File: tb/tb_mux_scan_serializer.sv
module tb_mux_scan_serializer;

   logic        clk;
   logic        rst;
   logic        load;
   logic [15:0] din;
   logic        msb_first;
   logic        in_ready;
   logic        sout_ready;
   logic        sout;
   logic        sout_valid;
   logic        sout_last;
   logic [3:0]  sel;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   // Observations captured by send_word (no checking inside it).
   logic       obs_bit[$];
   logic [3:0] obs_sel[$];
   logic       obs_last[$];
   int         stall_k[$];
   logic       stall_bit[$];
   logic [3:0] stall_sel[$];
   int         shift_cycles;
   bit         first_valid;
   bit         timeout;
   logic       done_a, valid_a, inr_a, done_b, inr_b;

   mux_scan_serializer dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .din        (din),
      .msb_first  (msb_first),
      .in_ready   (in_ready),
      .sout_ready (sout_ready),
      .sout       (sout),
      .sout_valid (sout_valid),
      .sout_last  (sout_last),
      .sel        (sel),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: beat k of a word carries bit (dir ? 15-k : k).
   function automatic logic exp_bit(input logic [15:0] w, input logic d, input int k);
      return d ? w[15-k] : w[k];
   endfunction

   function automatic logic [3:0] exp_sel(input logic d, input int k);
      return 4'(d ? 15 - k : k);
   endfunction

   // Drives one word through the block and records what was seen.
   // mode 0: sout_ready always 1; mode 1: random; mode 2: 3-cycle stalls at beats 0 and 7.
   task automatic send_word(input logic [15:0] w, input logic d, input int mode, input bit inject);
      int guard;
      int beat;
      int stalls;
      bit rdy;
      obs_bit.delete(); obs_sel.delete(); obs_last.delete();
      stall_k.delete(); stall_bit.delete(); stall_sel.delete();
      timeout = 0; first_valid = 0; shift_cycles = 0;
      done_a = 1'bx; valid_a = 1'bx; inr_a = 1'bx; done_b = 1'bx; inr_b = 1'bx;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         timeout = 1;
         return;
      end
      load = 1'b1; din = w; msb_first = d;
      @(posedge clk); #1;
      load = 1'b0; din = 16'($urandom); msb_first = 1'($urandom);
      beat = 0; stalls = 0; guard = 0;
      while (beat < 16 && guard < 200) begin
         rdy = 1'b1;
         if (mode == 1) begin
            rdy = ($urandom_range(0, 3) != 0);
         end else if (mode == 2 && (beat == 0 || beat == 7) && stalls < 3) begin
            rdy = 1'b0;
            stalls++;
         end
         sout_ready = rdy;
         load = inject && (beat == 5);
         if (load) din = 16'h1234;
         @(negedge clk);
         if (guard == 0) first_valid = sout_valid;
         if (sout_valid) begin
            shift_cycles++;
            if (sout_ready) begin
               obs_bit.push_back(sout);
               obs_sel.push_back(sel);
               obs_last.push_back(sout_last);
               beat++;
               stalls = 0;
            end else begin
               stall_k.push_back(beat);
               stall_bit.push_back(sout);
               stall_sel.push_back(sel);
            end
         end
         guard++;
         @(posedge clk); #1;
      end
      load = 1'b0;
      sout_ready = 1'b1;
      if (beat < 16) begin
         timeout = 1;
         return;
      end
      @(negedge clk);
      done_a = done; valid_a = sout_valid; inr_a = in_ready;
      @(posedge clk); #1;
      @(negedge clk);
      done_b = done; inr_b = in_ready;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      // rst high from time 0, before any clock edge
      #3;
      n_checks++;
      if ({in_ready, sout_valid, sel, done, sout, sout_last} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_values: got rdy=%b vld=%b sel=%0d done=%b sout=%b last=%b, need 1 0 0 0 0 0",
                  in_ready, sout_valid, sel, done, sout, sout_last);
      end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      load = 1'b1; din = 16'hFFFF; msb_first = 1'b1; sout_ready = 1'b0;
      @(posedge clk); #1;
      load = 1'b0;
      n_checks++;
      if ({sout_valid, sel} !== {1'b1, 4'd15}) begin
         n_fail++;
         $display("FAIL reset_pre_shift: got vld=%b sel=%0d, need vld=1 sel=15", sout_valid, sel);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({in_ready, sout_valid, sel, done, sout, sout_last} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_async: got rdy=%b vld=%b sel=%0d done=%b sout=%b last=%b, need 1 0 0 0 0 0",
                  in_ready, sout_valid, sel, done, sout, sout_last);
      end
      @(negedge clk); rst = 1'b0;
      $display("reset test: async reset checked");
   endtask

   task automatic test_lsb_first();
      logic [15:0] w = 16'hA5C3;
      send_word(w, 1'b0, 0, 1'b0);
      n_checks++;
      if (timeout !== 1'b0 || obs_bit.size() != 16) begin
         n_fail++;
         $display("FAIL lsb_beats: got %0d beats timeout=%b, need 16 beats timeout=0", obs_bit.size(), timeout);
      end
      for (int k = 0; k < obs_bit.size(); k++) begin
         n_checks++;
         if ({obs_bit[k], obs_sel[k], obs_last[k]} !== {exp_bit(w, 1'b0, k), exp_sel(1'b0, k), 1'(k == 15)}) begin
            n_fail++;
            $display("FAIL lsb_beat%0d: got bit=%b sel=%0d last=%b, need bit=%b sel=%0d last=%b", k,
                     obs_bit[k], obs_sel[k], obs_last[k], exp_bit(w, 1'b0, k), exp_sel(1'b0, k), k == 15);
         end
      end
      n_checks++;
      if ({first_valid, 5'(shift_cycles)} !== {1'b1, 5'd16}) begin
         n_fail++;
         $display("FAIL lsb_timing: got first_valid=%b cycles=%0d, need 1 and 16", first_valid, shift_cycles);
      end
      n_checks++;
      if ({done_a, valid_a, inr_a, done_b, inr_b} !== 5'b10001) begin
         n_fail++;
         $display("FAIL lsb_done: got done=%b vld=%b rdy=%b then done=%b rdy=%b, need 1 0 0 then 0 1",
                  done_a, valid_a, inr_a, done_b, inr_b);
      end
      $display("lsb_first: word %h, %0d beats", w, obs_bit.size());
   endtask

   task automatic test_msb_first();
      logic [15:0] w = 16'h8001;
      send_word(w, 1'b1, 0, 1'b0);
      n_checks++;
      if (timeout !== 1'b0 || obs_bit.size() != 16) begin
         n_fail++;
         $display("FAIL msb_beats: got %0d beats timeout=%b, need 16 beats timeout=0", obs_bit.size(), timeout);
      end
      for (int k = 0; k < obs_bit.size(); k++) begin
         n_checks++;
         if ({obs_bit[k], obs_sel[k], obs_last[k]} !== {exp_bit(w, 1'b1, k), exp_sel(1'b1, k), 1'(k == 15)}) begin
            n_fail++;
            $display("FAIL msb_beat%0d: got bit=%b sel=%0d last=%b, need bit=%b sel=%0d last=%b", k,
                     obs_bit[k], obs_sel[k], obs_last[k], exp_bit(w, 1'b1, k), exp_sel(1'b1, k), k == 15);
         end
      end
      n_checks++;
      if ({done_a, done_b, inr_b} !== 3'b101) begin
         n_fail++;
         $display("FAIL msb_done: got done=%b then done=%b rdy=%b, need 1 then 0 1", done_a, done_b, inr_b);
      end
      $display("msb_first: word %h, %0d beats", w, obs_bit.size());
   endtask

   task automatic test_backpressure();
      logic [15:0] w = 16'hFFFE;
      logic [15:0] rebuilt = '0;
      send_word(w, 1'b0, 2, 1'b0);
      n_checks++;
      if (timeout !== 1'b0 || obs_bit.size() != 16 || stall_k.size() != 6 || shift_cycles != 22) begin
         n_fail++;
         $display("FAIL bp_counts: got beats=%0d stalls=%0d cycles=%0d timeout=%b, need 16 6 22 0",
                  obs_bit.size(), stall_k.size(), shift_cycles, timeout);
      end
      for (int i = 0; i < stall_k.size(); i++) begin
         n_checks++;
         if ({stall_bit[i], stall_sel[i]} !== {exp_bit(w, 1'b0, stall_k[i]), exp_sel(1'b0, stall_k[i])}) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got bit=%b sel=%0d, need bit=%b sel=%0d", i, stall_bit[i], stall_sel[i],
                     exp_bit(w, 1'b0, stall_k[i]), exp_sel(1'b0, stall_k[i]));
         end
      end
      for (int k = 0; k < obs_bit.size(); k++) rebuilt[k] = obs_bit[k];
      n_checks++;
      if (rebuilt !== w) begin
         n_fail++;
         $display("FAIL bp_word: got %h, need %h", rebuilt, w);
      end
      n_checks++;
      if ({done_a, done_b} !== 2'b10) begin
         n_fail++;
         $display("FAIL bp_done: got %b%b, need 10", done_a, done_b);
      end
      $display("backpressure: word %h rebuilt %h, %0d stall cycles", w, rebuilt, stall_k.size());
   endtask

   task automatic test_load_ignored();
      logic [15:0] w = 16'h00FF;
      logic [15:0] rebuilt = '0;
      send_word(w, 1'b0, 0, 1'b1);
      for (int k = 0; k < obs_bit.size(); k++) rebuilt[k] = obs_bit[k];
      n_checks++;
      if (timeout !== 1'b0 || obs_bit.size() != 16 || rebuilt !== w) begin
         n_fail++;
         $display("FAIL load_ignored: got %h (%0d beats), need %h (16 beats)", rebuilt, obs_bit.size(), w);
      end
      n_checks++;
      if ({done_a, done_b, inr_b} !== 3'b101) begin
         n_fail++;
         $display("FAIL load_ignored_done: got %b %b %b, need 1 0 1", done_a, done_b, inr_b);
      end
      $display("load_ignored: word %h rebuilt %h", w, rebuilt);
   endtask

   task automatic test_reset_mid_word();
      int guard = 0;
      bit saw_done = 0;
      logic [15:0] w2 = 16'h0001;
      @(negedge clk);
      load = 1'b1; din = 16'hFFFF; msb_first = 1'b0; sout_ready = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      @(negedge clk);
      while (!(sout_valid && sel == 4'd9) && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (!(sout_valid && sel == 4'd9)) begin
         n_fail++;
         $display("FAIL midrst_reach: got vld=%b sel=%0d, need vld=1 sel=9", sout_valid, sel);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({in_ready, sout_valid, sel, done, sout, sout_last} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL midrst_clear: got rdy=%b vld=%b sel=%0d done=%b sout=%b last=%b, need 1 0 0 0 0 0",
                  in_ready, sout_valid, sel, done, sout, sout_last);
      end
      @(negedge clk); #2 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done || sout_valid) saw_done = 1;
      end
      n_checks++;
      if (saw_done !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_nodone: got activity after reset=1, need 0");
      end
      send_word(w2, 1'b0, 0, 1'b0);
      n_checks++;
      if (timeout !== 1'b0 || obs_bit.size() != 16) begin
         n_fail++;
         $display("FAIL midrst_next_beats: got %0d beats, need 16", obs_bit.size());
      end
      for (int k = 0; k < obs_bit.size(); k++) begin
         n_checks++;
         if ({obs_bit[k], obs_sel[k], obs_last[k]} !== {exp_bit(w2, 1'b0, k), exp_sel(1'b0, k), 1'(k == 15)}) begin
            n_fail++;
            $display("FAIL midrst_beat%0d: got bit=%b sel=%0d last=%b, need bit=%b sel=%0d last=%b", k,
                     obs_bit[k], obs_sel[k], obs_last[k], exp_bit(w2, 1'b0, k), exp_sel(1'b0, k), k == 15);
         end
      end
      $display("reset_mid_word: aborted at sel=9, next word %h sent", w2);
   endtask

   task automatic test_random();
      logic [15:0] w;
      logic        d;
      int          bad;
      for (int t = 0; t < 8; t++) begin
         w = 16'($urandom);
         d = 1'($urandom);
         send_word(w, d, 1, 1'($urandom));
         n_checks++;
         if (timeout !== 1'b0 || obs_bit.size() != 16) begin
            n_fail++;
            $display("FAIL rand%0d_beats: got %0d beats, need 16", t, obs_bit.size());
         end
         bad = 0;
         for (int k = 0; k < obs_bit.size(); k++) begin
            if ({obs_bit[k], obs_sel[k], obs_last[k]} !== {exp_bit(w, d, k), exp_sel(d, k), 1'(k == 15)}) bad++;
         end
         n_checks++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL rand%0d_stream: got %0d wrong beats for word %h dir %b, need 0", t, bad, w, d);
         end
         n_checks++;
         if ({done_a, valid_a, inr_a, done_b, inr_b} !== 5'b10001) begin
            n_fail++;
            $display("FAIL rand%0d_done: got %b%b%b%b%b, need 10001", t, done_a, valid_a, inr_a, done_b, inr_b);
         end
         $display("random %0d: word %h dir %b, %0d cycles in shift", t, w, d, shift_cycles);
      end
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; din = '0; msb_first = 1'b0; sout_ready = 1'b0;
      test_reset();
      test_lsb_first();
      test_msb_first();
      test_backpressure();
      test_load_ignored();
      test_reset_mid_word();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_mux_scan_serializer

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
- Upstream sequencing stage for the 16:1 bit selector; loads a 16-bit word and sweeps a 4-bit select through all positions, emitting one bit per accepted beat.
- Turns the combinational selector into a parallel-to-serial converter, with valid/ready handshakes on both sides.
- Serial output goes to downstream shift/display logic.

Parameters:
- WIDTH, 16, data word width; must equal 2**SEL_W.
- SEL_W, 4, select width; sets the number of beats per word.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  input valid; word accepted when load && in_ready.
- din  in  WIDTH  parallel word, captured on acceptance.
- msb_first  in  1  direction, captured on acceptance; 1 = bit 15 first, 0 = bit 0 first.
- in_ready  out  1  block can accept a word.
- sout_ready  in  1  downstream accepts the current bit.
- sout  out  1  selected bit, data_reg[sel].
- sout_valid  out  1  sout is valid.
- sout_last  out  1  current bit is the final bit of the word.
- sel  out  SEL_W  current select value, exported for debug/LEDs.
- done  out  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: state=IDLE, data_reg=0, dir=0, sel=0, in_ready=1, sout=0, sout_valid=0, sout_last=0, done=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, sout_valid=0.
  - On load: data_reg<=din, dir<=msb_first, sel<=(msb_first ? WIDTH-1 : 0), next state SHIFT.
  - Latency: first bit is valid on the cycle after acceptance.
- SHIFT:
  - in_ready=0, sout_valid=1.
  - sout = data_reg[sel], combinational through the selector sub-module from registered data_reg and sel.
  - sout_last=1 when sel equals the end index (0 if dir=1, WIDTH-1 if dir=0).
- Handshake:
  - Beat accepted when sout_valid && sout_ready.
  - Accepted, not last: sel steps by +1 (dir=0) or -1 (dir=1).
  - Accepted, last: next state DONE; sel keeps its final value.
  - sout_ready=0: sel, sout, sout_valid and sout_last all hold. No bit is dropped or repeated.
- DONE:
  - done=1 for exactly one cycle; in_ready=0, sout_valid=0.
  - Then IDLE unconditionally.
- Throughput: minimum 1 + WIDTH + 1 cycles per word (accept, 16 beats, DONE), i.e. 18 for the default.
- sel never wraps; the sweep is bounded by the start and end indices.
- load during SHIFT or DONE is ignored; din and msb_first changes after acceptance have no effect.
- Reset mid-word aborts immediately with no partial completion and no done pulse.
- sout is don't-care when sout_valid=0 but must not be X after reset; it is driven from data_reg=0 and sel=0.

Decomposition:
- Shared package / header:
  - state encoding IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - constants WIDTH=16, SEL_W=4.
- Sub-module sel16_mux (16-bit in, 4-bit select, 1-bit out), built as a tree of 4:1 selectors.
- Top-level holds the FSM, sel counter, data and direction registers, and handshake logic.

Test Plan:
- Reset then idle -> in_ready=1, sout_valid=0, sel=0, done=0; assert rst mid-cycle and check outputs clear without a clock edge.
- LSB-first, din=16'hA5C3, msb_first=0, sout_ready=1 -> bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over 16 cycles; sel 0..15; sout_last only at sel=15; done one cycle later; in_ready=1 the cycle after that.
- MSB-first, din=16'h8001, msb_first=1 -> first bit 1 at sel=15, bits 14..1 are 0, last bit 1 at sel=0 with sout_last=1.
- Backpressure: din=16'hFFFE LSB-first, sout_ready low for 3 cycles at sel=0 and at sel=7 -> sel and sout hold (0 then 1); total 16 accepted beats; word reproduced exactly.
- load pulsed with din=16'h1234 during SHIFT of 16'h00FF -> ignored; output stream is 00FF only.
- rst asserted at sel=9 of 16'hFFFF -> immediate return to reset values, no done pulse; a subsequent load of 16'h0001 serializes correctly from sel=0.
